// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - rx_state_t : receiver FSM states (PARITY present only when the
//                  UART_RX_PARITY_EN macro is defined)
//   - PAR_NONE / PAR_EVEN / PAR_ODD : parity-mode encodings for PARITY_MODE
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous, active-high reset; both flops load RESET_VAL
//   d    - asynchronous input
//   q    - synchronised output (two clk cycles of latency)
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop framing with a
// single-entry output register and valid/ready handshake.
// Build option: define UART_RX_PARITY_EN to compile in the PARITY state and
// the parity check (selected by PARITY_MODE); otherwise parity_err is 0.
// Ports:
//   clk, rst    - clock; asynchronous active-high reset
//   serial_in   - asynchronous serial line, idle high
//   rx_data     - received word (LSB first on the line)
//   rx_valid    - rx_data / frame_err / parity_err hold a frame
//   rx_ready    - consumer accepts the word while rx_valid is high
//   frame_err   - delivered frame had a low stop bit
//   parity_err  - delivered frame failed its parity check
//   overrun     - one-cycle pulse: a finished frame was dropped (output full)
//   rx_busy     - FSM is outside IDLE
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam logic [CW-1:0] MID_CNT   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam bit        PAR_ON     = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
    localparam logic      PAR_INV    = (PARITY_MODE == PAR_ODD);
    localparam rx_state_t AFTER_DATA = PAR_ON ? PARITY : STOP;
`else
    localparam rx_state_t AFTER_DATA = STOP;
    logic unused_cfg;
    assign unused_cfg = (PARITY_MODE != PAR_NONE);
`endif

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 ferr_q;
    logic                 done_q;
    logic                 rx_s;
    logic                 mid, bit_end, last_stop;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_s)
    );

    assign mid       = (cnt_q == MID_CNT);
    assign bit_end   = (cnt_q == LAST_CNT);
    // Leave STOP at the last mid-sample, half a bit early, so a start bit
    // that follows immediately is not missed.
    assign last_stop = (state_q == STOP) && mid && (idx_q == LAST_STOP);
    assign rx_busy   = (state_q != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (!rx_s) state_d = START;
            START: begin
                if (mid && rx_s) state_d = IDLE;       // false start
                else if (bit_end) state_d = DATA;
            end
            DATA:   if (bit_end && idx_q == LAST_DATA) state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:   if (last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- bit timing / datapath ----------------
`ifdef UART_RX_PARITY_EN
    logic perr_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= last_stop;
            if (state_q == IDLE) begin
                // Error flags are read by the output stage during the first
                // IDLE cycle and cleared at its end.
                cnt_q  <= '0;
                idx_q  <= '0;
                ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_q <= 1'b0;
`endif
            end else begin
                cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
                case (state_q)
                    DATA: begin
                        if (mid) shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_end) idx_q <= (idx_q == LAST_DATA) ? '0 : idx_q + IW'(1);
                    end
`ifdef UART_RX_PARITY_EN
                    // Data ones plus parity bit must be even (or odd).
                    PARITY: if (mid) perr_q <= rx_s ^ (^shreg_q) ^ PAR_INV;
`endif
                    STOP: begin
                        if (mid && !rx_s) ferr_q <= 1'b1;
                        if (bit_end) idx_q <= idx_q + IW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- output register / handshake ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_q) begin
                // A handshake in the delivery cycle frees the slot in time.
                if (!rx_valid || rx_ready) begin
                    rx_data   <= shreg_q;
                    frame_err <= ferr_q;
                    rx_valid  <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else if (done_q && (!rx_valid || rx_ready)) parity_err <= perr_q;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 50, clk cycles per serial bit (legal values ≥ 4).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (legal values 5..9).
REQ-003 Parameter STOP_BITS, default 1, stop bits checked per frame (legal values 1 or 2).
REQ-004 Parameter PARITY_MODE, default 0, parity type: 0 none, 1 even, 2 odd (honoured only with UART_RX_PARITY_EN).
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 serial_in  in  1  asynchronous serial line, idle high.
REQ-008 rx_data  out  DATA_BITS  received word, LSB first on the line.
REQ-009 rx_valid  out  1  rx_data and error flags hold a valid frame.
REQ-010 rx_ready  in  1  consumer accepts the word when rx_valid=1.
REQ-011 frame_err  out  1  delivered frame had a low stop bit; qualified by rx_valid.
REQ-012 parity_err  out  1  delivered frame failed the parity check; qualified by rx_valid.
REQ-013 overrun  out  1  one-cycle pulse: a completed frame was dropped because the output was still full.
REQ-014 rx_busy  out  1  high in every state other than IDLE.

Function
REQ-015 serial_in shall pass through a 2-flop synchroniser before any use; the synchroniser resets to 1.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE->START on a synchronised low; the bit counter clears.
REQ-018 Bit counter: width $clog2(CLKS_PER_BIT).
  - Mid-bit sample point: count == (CLKS_PER_BIT-1)/2.
  - Bit end: count == CLKS_PER_BIT-1; counter wraps to 0.
REQ-019 START: if the mid-bit sample is high, the FSM shall treat it as a false start, return to IDLE, and produce no output.
REQ-020 START: otherwise, at bit end, go to DATA.
REQ-021 DATA: sample DATA_BITS bits at mid-bit, shifting LSB first.
  - After the last bit end, go to PARITY if parity is enabled, else STOP.
REQ-022 PARITY: compare the mid-bit sample against the even/odd parity of the data bits; on bit end, go to STOP.
REQ-023 STOP: sample STOP_BITS bits at mid-bit; any low sample sets frame_err for this frame.
REQ-024 STOP: after the final stop-bit mid-sample, go to IDLE immediately (half a bit early) so back-to-back frames are received.
REQ-025 Delivery: the cycle after the final stop-bit sample, load rx_data, frame_err and parity_err, and set rx_valid.
  - Frames with errors are still delivered.
REQ-026 rx_valid, rx_data and the error flags shall hold stable until a cycle with rx_valid=1 and rx_ready=1; rx_valid then clears.
REQ-027 Delivery while rx_valid=1 and rx_ready=0:
  - Pulse overrun for one cycle.
  - Discard the new frame; keep the old word.
REQ-028 Delivery in the same cycle as a handshake (rx_valid=1, rx_ready=1): load the new frame, keep rx_valid=1, no overrun.
REQ-029 Deassertion of rx_ready shall never stall reception.

Reset
REQ-030 On rst:
  - FSM goes to IDLE; counters clear; shift register clears.
  - rx_data=0; rx_valid, frame_err, parity_err, overrun and rx_busy =0.
REQ-031 rst mid-frame shall abandon the partial frame with no output; the next falling edge after reset starts a fresh frame.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: the PARITY state and parity check are compiled in, controlled by PARITY_MODE.
REQ-033 Macro UART_RX_PARITY_EN undefined: PARITY_MODE is ignored, the PARITY state is absent, and parity_err is tied to 0.

Structure
REQ-034 Shared package uart_pkg shall hold the FSM state enum and the parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-035 The synchroniser shall be a sub-module uart_sync2 (parameter RESET_VAL, default 1).
  - All other logic resides in uart_rx_core.

Verification
Default configuration for all scenarios: CLKS_PER_BIT=50, DATA_BITS=8, STOP_BITS=1, unless stated.
REQ-036 Frame 0xA5, 8N1, rx_ready=1 -> one rx_valid cycle, rx_data=0xA5, frame_err=0, parity_err=0.
REQ-037 Low glitch of 10 clk on serial_in -> no rx_valid; rx_busy returns to 0 within 30 clk.
REQ-038 Frame 0x3C with stop bit driven 0 -> rx_data=0x3C, frame_err=1.
REQ-039 Back-to-back frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, one overrun pulse.
  - Then raise rx_ready -> 0x11 accepted; rx_valid drops.
REQ-040 UART_RX_PARITY_EN defined, PARITY_MODE=1, frame 0x07 with parity bit 0 -> parity_err=1.
  - Same frame with parity bit 1 -> parity_err=0.
REQ-041 rst asserted during bit 4 of 0xFF, then frame 0x5A sent -> only 0x5A delivered, no errors.
